// File: rtl/i2c_req_arbiter.sv
// ---------------------------------------------------------------------------
// i2c_req_arbiter
//
// Purpose:
//   Shares a single i2c_master between NREQ client blocks. Requests are
//   arbitrated round-robin. Each grant sequences exactly one single-byte
//   transfer on the master, then returns read data and status to the winner
//   with a one-cycle done pulse.
//
// Optional feature:
//   I2C_ARB_TIMEOUT_EN - when defined, a 16-bit watchdog limits the time spent
//   in LAUNCH+WAIT_DONE to TIMEOUT_CYCLES clocks; on expiry the transfer is
//   completed with rsp_timeout=1, rsp_nack=1, rsp_rdata=0x00. When undefined,
//   the FSM waits on m_ready indefinitely and rsp_timeout is tied low.
//
// Ports:
//   clk, reset_n              clock (rising edge), async active-low reset
//   req[NREQ]                 request level per client, held until done[i]
//   req_addr[7*NREQ]          7-bit slave address per client
//   req_rw[NREQ]              1 = read, 0 = write
//   req_wdata[8*NREQ]         write byte per client
//   gnt[NREQ]                 one-hot grant, high from grant through RESP
//   done[NREQ]                one-cycle completion pulse to the winner
//   rsp_rdata/nack/timeout    response, valid while done != 0, held after
//   busy                      FSM not idle
//   m_enable/address/rw/txdata/restart   to i2c_master
//   m_ready/ack/nack/rxdata   from i2c_master
// ---------------------------------------------------------------------------
module i2c_req_arbiter #(
  parameter int NREQ           = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NREQ-1:0]     req,
  input  logic [7*NREQ-1:0]   req_addr,
  input  logic [NREQ-1:0]     req_rw,
  input  logic [8*NREQ-1:0]   req_wdata,
  output logic [NREQ-1:0]     gnt,
  output logic [NREQ-1:0]     done,
  output logic [7:0]          rsp_rdata,
  output logic                rsp_nack,
  output logic                rsp_timeout,
  output logic                busy,
  output logic                m_enable,
  output logic [6:0]          m_address,
  output logic                m_rw,
  output logic [7:0]          m_txdata,
  output logic                m_restart,
  input  logic                m_ready,
  input  logic                m_ack,
  input  logic                m_nack,
  input  logic [7:0]          m_rxdata
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LAUNCH    = 2'd1,
    S_WAIT_DONE = 2'd2,
    S_RESP      = 2'd3
  } state_t;

  state_t          r_state;
  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   r_win;
  logic [NREQ-1:0] r_gnt;
  logic [NREQ-1:0] r_done;
  logic [7:0]      r_rdata;
  logic            r_nack_out;
  logic            r_nack_sticky;
  logic            r_enable;
  logic [6:0]      r_addr;
  logic            r_rw;
  logic [7:0]      r_tx;

  logic [PW-1:0]   w_win;
  logic [PW-1:0]   w_idx;
  logic            w_found;
  logic [NREQ-1:0] w_win_onehot;
  logic            w_wdog_expired;
  logic            w_unused;

  // Round-robin search: first set request starting just above the pointer.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = PW'((int'(r_ptr) + k) % NREQ);
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_onehot
      assign w_win_onehot[gi] = (w_win == PW'(gi));
    end
  endgenerate

`ifdef I2C_ARB_TIMEOUT_EN
  logic [15:0] r_wdog;
  logic        r_timeout;

  // Expiry is flagged in the last allowed cycle so done lands exactly
  // TIMEOUT_CYCLES clocks after the grant.
  assign w_wdog_expired = (r_wdog == 16'(TIMEOUT_CYCLES - 1));
  assign rsp_timeout    = r_timeout;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wdog <= '0;
    end else if (r_state == S_LAUNCH || r_state == S_WAIT_DONE) begin
      r_wdog <= r_wdog + 16'd1;
    end else begin
      r_wdog <= '0;
    end
  end
`else
  assign w_wdog_expired = 1'b0;
  assign rsp_timeout    = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_ptr         <= PW'(NREQ - 1);
      r_win         <= '0;
      r_gnt         <= '0;
      r_done        <= '0;
      r_rdata       <= '0;
      r_nack_out    <= 1'b0;
      r_nack_sticky <= 1'b0;
      r_enable      <= 1'b0;
      r_addr        <= '0;
      r_rw          <= 1'b0;
      r_tx          <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
      r_timeout     <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          // Only arbitrate when the master is idle; requests simply wait.
          if (m_ready && w_found) begin
            r_win         <= w_win;
            r_gnt         <= w_win_onehot;
            r_addr        <= req_addr[7*w_win +: 7];
            r_rw          <= req_rw[w_win];
            r_tx          <= req_wdata[8*w_win +: 8];
            r_nack_sticky <= 1'b0;
            r_state       <= S_LAUNCH;
          end
        end

        S_LAUNCH: begin
          if (w_wdog_expired) begin
            r_enable   <= 1'b0;
            r_done     <= r_gnt;
            r_rdata    <= 8'h00;
            r_nack_out <= 1'b1;
`ifdef I2C_ARB_TIMEOUT_EN
            r_timeout  <= 1'b1;
`endif
            r_state    <= S_RESP;
          end else if (!r_enable) begin
            // enable rises one cycle after gnt
            r_enable <= 1'b1;
          end else if (!m_ready) begin
            // master has accepted the command
            r_enable <= 1'b0;
            r_state  <= S_WAIT_DONE;
          end
        end

        S_WAIT_DONE: begin
          if (w_wdog_expired) begin
            r_done     <= r_gnt;
            r_rdata    <= 8'h00;
            r_nack_out <= 1'b1;
`ifdef I2C_ARB_TIMEOUT_EN
            r_timeout  <= 1'b1;
`endif
            r_state    <= S_RESP;
          end else begin
            // nack may pulse at any point of the transfer; keep it sticky
            r_nack_sticky <= r_nack_sticky | m_nack;
            if (m_ready) begin
              r_done     <= r_gnt;
              r_rdata    <= r_rw ? m_rxdata : 8'h00;
              r_nack_out <= r_nack_sticky | m_nack;
`ifdef I2C_ARB_TIMEOUT_EN
              r_timeout  <= 1'b0;
`endif
              r_state    <= S_RESP;
            end
          end
        end

        S_RESP: begin
          r_done  <= '0;
          r_gnt   <= '0;
          r_ptr   <= r_win;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign done      = r_done;
  assign rsp_rdata = r_rdata;
  assign rsp_nack  = r_nack_out;
  assign busy      = (r_state != S_IDLE);
  assign m_enable  = r_enable;
  assign m_address = r_addr;
  assign m_rw      = r_rw;
  assign m_txdata  = r_tx;
  assign m_restart = 1'b0;

  // m_ack is informational only
  assign w_unused = m_ack ^ 1'(TIMEOUT_CYCLES % 2);

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_i2c_req_arbiter
//   Scoreboard bench: stimulus pushes expected launches and responses into
//   queues; a behavioural i2c_master pops launches, a monitor pops responses
//   whenever done is seen.
// ---------------------------------------------------------------------------
module tb_i2c_req_arbiter;

  localparam int NREQ = 4;

  logic              clk;
  logic              reset_n;
  logic [NREQ-1:0]   req;
  logic [7*NREQ-1:0] req_addr;
  logic [NREQ-1:0]   req_rw;
  logic [8*NREQ-1:0] req_wdata;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic [7:0]        rsp_rdata;
  logic              rsp_nack;
  logic              rsp_timeout;
  logic              busy;
  logic              m_enable;
  logic [6:0]        m_address;
  logic              m_rw;
  logic [7:0]        m_txdata;
  logic              m_restart;
  logic              m_ready;
  logic              m_ack;
  logic              m_nack;
  logic [7:0]        m_rxdata;

  i2c_req_arbiter #(.NREQ(NREQ), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_addr(req_addr),
    .req_rw(req_rw), .req_wdata(req_wdata), .gnt(gnt), .done(done),
    .rsp_rdata(rsp_rdata), .rsp_nack(rsp_nack), .rsp_timeout(rsp_timeout),
    .busy(busy), .m_enable(m_enable), .m_address(m_address), .m_rw(m_rw),
    .m_txdata(m_txdata), .m_restart(m_restart), .m_ready(m_ready),
    .m_ack(m_ack), .m_nack(m_nack), .m_rxdata(m_rxdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         client;
    logic [7:0] rdata;
    logic       nack;
    logic       to;
  } rsp_t;

  typedef struct {
    logic [6:0] addr;
    logic       rw;
    logic [7:0] tx;
  } launch_t;

  rsp_t    exp_q[$];
  launch_t launch_q[$];
  int      remaining[NREQ];
  int      n_checks = 0;
  int      n_pass   = 0;

  // master model controls
  logic    hold_low = 1'b0;
  logic    stuck    = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic present(input logic [6:0] a);
    return (a == 7'h50) || (a == 7'h51);
  endfunction

  function automatic logic [7:0] slave_rd(input logic [6:0] a);
    if (a == 7'h51) return 8'hBB;
    if (a == 7'h50) return 8'h3C;
    return 8'hFF;
  endfunction

  function automatic logic any_pending();
    for (int i = 0; i < NREQ; i++) if (remaining[i] != 0) return 1'b1;
    return 1'b0;
  endfunction

  // queue one transaction for client c with hand-computed response
  task automatic issue(input int c, input logic [6:0] a, input logic rw, input logic [7:0] wd,
                       input logic [7:0] exp_rd, input logic exp_nack);
    launch_t l;
    rsp_t    r;
    req_addr[7*c +: 7]  = a;
    req_rw[c]           = rw;
    req_wdata[8*c +: 8] = wd;
    l.addr = a; l.rw = rw; l.tx = wd;
    launch_q.push_back(l);
    r.client = c; r.rdata = exp_rd; r.nack = exp_nack; r.to = 1'b0;
    exp_q.push_back(r);
    $display("issue: client %0d addr 0x%02h rw %0d wdata 0x%02h", c, a, rw, wd);
  endtask

  task automatic wait_quiet(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy || req != 0 || any_pending()) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    n_checks++;
    if (n < 2000) n_pass++;
    else $display("FAIL %s: still active after %0d cycles, expected completion", name, n);
  endtask

  // request driver: level held until the client's done
  initial begin
    req = '0;
    for (int i = 0; i < NREQ; i++) remaining[i] = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (done[i] && remaining[i] > 0) remaining[i]--;
        req[i] = (remaining[i] != 0);
      end
    end
  end

  // behavioural i2c_master
  initial begin
    int         busy_cnt;
    logic [6:0] cur_addr;
    logic       cur_rw;
    launch_t    l;
    busy_cnt = 0; cur_addr = '0; cur_rw = 1'b0;
    m_ready = 1'b1; m_ack = 1'b0; m_nack = 1'b0; m_rxdata = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n) begin
        m_ready = 1'b1; m_nack = 1'b0; busy_cnt = 0;
      end else if (hold_low) begin
        m_ready = 1'b0;
      end else if (stuck) begin
        m_ready = 1'b1;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
        m_nack = (busy_cnt == 2) && !present(cur_addr);
        if (busy_cnt == 0) begin
          m_ready  = 1'b1;
          m_ack    = present(cur_addr);
          m_rxdata = cur_rw ? slave_rd(cur_addr) : 8'hA5;
        end
      end else if (!m_ready) begin
        m_ready = 1'b1;
      end else if (m_enable) begin
        if (launch_q.size() == 0) begin
          chk("unexpected_launch", 64'(m_enable), 64'd0);
        end else begin
          l = launch_q.pop_front();
          chk("launch_addr", 64'(m_address), 64'(l.addr));
          chk("launch_rw", 64'(m_rw), 64'(l.rw));
          chk("launch_txdata", 64'(m_txdata), 64'(l.tx));
          $display("master: launch addr 0x%02h rw %0d tx 0x%02h", m_address, m_rw, m_txdata);
        end
        cur_addr = m_address; cur_rw = m_rw;
        m_ready = 1'b0; m_ack = 1'b0; busy_cnt = 5;
      end
    end
  end

  // response monitor
  rsp_t mon_e;
  initial begin
    forever begin
      @(negedge clk);
      if (gnt != '0) chk("gnt_onehot", 64'($countones(gnt)), 64'd1);
      if (done != '0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 64'(done), 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("done_client", 64'(done), 64'(1 << mon_e.client));
          chk("gnt_at_done", 64'(gnt), 64'(1 << mon_e.client));
          chk("rsp_rdata", 64'(rsp_rdata), 64'(mon_e.rdata));
          chk("rsp_nack", 64'(rsp_nack), 64'(mon_e.nack));
          chk("rsp_timeout", 64'(rsp_timeout), 64'(mon_e.to));
          chk("busy_at_done", 64'(busy), 64'd1);
          $display("resp: done 0x%0h rdata 0x%02h nack %0d timeout %0d",
                   done, rsp_rdata, rsp_nack, rsp_timeout);
        end
      end
    end
  end

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int k;
    int n;
    reset_n   = 1'b0;
    req_addr  = '0;
    req_rw    = '0;
    req_wdata = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // reset state
    chk("reset_gnt_done", 64'({gnt, done}), 64'd0);
    chk("reset_rsp", 64'({rsp_rdata, rsp_nack, rsp_timeout, busy}), 64'd0);
    chk("reset_master_if", 64'({m_enable, m_address, m_rw, m_txdata, m_restart}), 64'd0);

    // T1 write with latency checks
    issue(0, 7'h50, 1'b0, 8'hFE, 8'h00, 1'b0);
    @(posedge clk); #1;
    remaining[0] = 1;
    @(negedge clk);               // req rises here
    @(negedge clk);
    chk("t1_gnt_latency", 64'(gnt), 64'b0001);
    chk("t1_enable_not_yet", 64'(m_enable), 64'd0);
    @(negedge clk);
    chk("t1_enable_latency", 64'(m_enable), 64'd1);
    chk("t1_restart", 64'(m_restart), 64'd0);
    wait_quiet("t1_write");

    // T2 read
    issue(1, 7'h51, 1'b1, 8'h00, 8'hBB, 1'b0);
    remaining[1] = 1;
    wait_quiet("t2_read");
    repeat (3) @(negedge clk);
    chk("t2_rsp_hold", 64'(rsp_rdata), 64'hBB);

    // T3 absent slave
    issue(2, 7'h52, 1'b0, 8'h11, 8'h00, 1'b1);
    remaining[2] = 1;
    wait_quiet("t3_absent");
    chk("t3_idle_after_nack", 64'(busy), 64'd0);

    // master busy in IDLE: no grant until it is ready
    hold_low = 1'b1;
    repeat (2) @(negedge clk);
    issue(2, 7'h50, 1'b0, 8'h77, 8'h00, 1'b0);
    remaining[2] = 1;
    repeat (6) @(negedge clk);
    chk("no_grant_master_busy", 64'(gnt), 64'd0);
    hold_low = 1'b0;
    wait_quiet("ready_low_wait");

    // T4 fairness from reset pointer: order 0,1,2,3,0
    do_reset();
    issue(0, 7'h50, 1'b0, 8'h01, 8'h00, 1'b0);
    issue(1, 7'h51, 1'b1, 8'h00, 8'hBB, 1'b0);
    issue(2, 7'h50, 1'b0, 8'h22, 8'h00, 1'b0);
    issue(3, 7'h51, 1'b1, 8'h00, 8'hBB, 1'b0);
    issue(0, 7'h50, 1'b0, 8'h01, 8'h00, 1'b0);
    remaining[0] = 2; remaining[1] = 1; remaining[2] = 1; remaining[3] = 1;
    wait_quiet("t4_fairness");

    // T5 reset in WAIT_DONE
    begin
      launch_t l;
      req_addr[7*1 +: 7] = 7'h50; req_rw[1] = 1'b0; req_wdata[8*1 +: 8] = 8'h5A;
      l.addr = 7'h50; l.rw = 1'b0; l.tx = 8'h5A;
      launch_q.push_back(l);
    end
    remaining[1] = 1;
    k = 0;
    while (!m_enable && k < 50) begin @(negedge clk); k++; end
    while (m_enable && k < 50) begin @(negedge clk); k++; end
    chk("t5_reached_wait", 64'(k < 50), 64'd1);
    @(negedge clk);
    reset_n = 1'b0;
    remaining[1] = 0;
    #1;
    chk("t5_async_gnt_done", 64'({gnt, done, busy}), 64'd0);
    chk("t5_async_master_if", 64'({m_enable, m_address, m_rw, m_txdata}), 64'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    launch_q.delete();
    issue(3, 7'h51, 1'b1, 8'h00, 8'hBB, 1'b0);
    remaining[3] = 1;
    wait_quiet("t5_after_reset");

`ifdef I2C_ARB_TIMEOUT_EN
    // T6 watchdog with m_ready stuck high
    begin
      rsp_t r;
      stuck = 1'b1;
      r.client = 0; r.rdata = 8'h00; r.nack = 1'b1; r.to = 1'b1;
      exp_q.push_back(r);
      req_addr[6:0] = 7'h50; req_rw[0] = 1'b0; req_wdata[7:0] = 8'h99;
      remaining[0] = 1;
      k = 0;
      while (!gnt[0] && k < 50) begin @(negedge clk); k++; end
      n = 0;
      while (done == '0 && n < 200) begin @(negedge clk); n++; end
      chk("t6_timeout_latency", 64'(n), 64'd64);
      stuck = 1'b0;
      wait_quiet("t6_timeout");
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1, "global timeout");
  end

endmodule
